// File: rtl/alu_input_loader.sv
// ALU front end: loads operand A, operand B and the op code from the slide
// switches, one target per debounced push-button press.
module alu_input_loader #(
  parameter int ND_DATA         = 4,
  parameter int NB_OP           = 6,
  parameter int NB_SW           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_SW-1:0]   i_sw,
  input  logic [2:0]         i_btn,
  output logic [ND_DATA-1:0] o_datoA,
  output logic [ND_DATA-1:0] o_datoB,
  output logic [NB_OP-1:0]   o_operation,
  output logic [2:0]         o_load_strobe,
  output logic [2:0]         o_loaded,
  output logic               o_all_loaded
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NB_SW-1:0]   sw_s1_q, sw_s1_d;
  logic [NB_SW-1:0]   sw_s2_q, sw_s2_d;
  logic [2:0]         btn_s1_q, btn_s1_d;
  logic [2:0]         btn_s2_q, btn_s2_d;
  logic [2:0]         deb_q, deb_d;
  logic [2:0][CW-1:0] cnt_q, cnt_d;
  logic [ND_DATA-1:0] dato_a_q, dato_a_d;
  logic [ND_DATA-1:0] dato_b_q, dato_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [2:0]         strobe_q, strobe_d;
  logic [2:0]         loaded_q, loaded_d;
  logic [2:0]         rise;

  always_comb begin
    sw_s1_d  = i_sw;
    sw_s2_d  = sw_s1_q;
    btn_s1_d = i_btn;
    btn_s2_d = btn_s1_q;
    deb_d    = deb_q;
    cnt_d    = '0;

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    for (int k = 0; k < 3; k++) begin
      if (btn_s2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == CNT_LAST) begin
          deb_d[k] = btn_s2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
      end
    end

    rise     = deb_d & ~deb_q;
    dato_a_d = rise[0] ? sw_s2_q[ND_DATA-1:0] : dato_a_q;
    dato_b_d = rise[1] ? sw_s2_q[ND_DATA-1:0] : dato_b_q;
    op_d     = rise[2] ? sw_s2_q[NB_OP-1:0]   : op_q;
    strobe_d = rise;
    loaded_d = loaded_q | rise;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      deb_q    <= '0;
      cnt_q    <= '0;
      dato_a_q <= '0;
      dato_b_q <= '0;
      op_q     <= '0;
      strobe_q <= '0;
      loaded_q <= '0;
    end else begin
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
      btn_s1_q <= btn_s1_d;
      btn_s2_q <= btn_s2_d;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      dato_a_q <= dato_a_d;
      dato_b_q <= dato_b_d;
      op_q     <= op_d;
      strobe_q <= strobe_d;
      loaded_q <= loaded_d;
    end
  end

  assign o_datoA       = dato_a_q;
  assign o_datoB       = dato_b_q;
  assign o_operation   = op_q;
  assign o_load_strobe = strobe_q;
  assign o_loaded      = loaded_q;
  assign o_all_loaded  = &loaded_q;

endmodule
